// File: rtl/inst_fetch.sv
// Instruction fetch front end: PC register, direct-mapped icache (one word
// per line), 2-bit branch history table and a two-state miss FSM. Issues at
// most one instruction per cycle to the decoder, redirects on ROB rollback.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          ICACHE_IDX = 8,
  parameter int          BHT_IDX    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback,
  input  logic [31:0] rollback_pc,
  input  logic        issue_stall,
  output logic        inst_done,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        pre_j,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  input  logic        bp_upd,
  input  logic [31:0] bp_pc,
  input  logic        bp_taken
);

  localparam int LINES = 1 << ICACHE_IDX;
  localparam int TAG_W = 32 - ICACHE_IDX - 2;
  localparam int BHT_N = 1 << BHT_IDX;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        inst_done_q, inst_done_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        pre_j_q, pre_j_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        fill_we;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];
  logic [1:0]       bht_q  [BHT_N];

  logic [ICACHE_IDX-1:0] line_idx;
  logic [TAG_W-1:0]      line_tag;
  logic [31:0]           line;
  logic                  hit;
  logic [BHT_IDX-1:0]    bht_rd_idx;
  logic [BHT_IDX-1:0]    bht_wr_idx;
  logic [31:0]           npc;
  logic                  pred_taken;
  logic                  bp_unused;

  function automatic logic signed [31:0] imm_j(input logic [31:0] w);
    imm_j = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  function automatic logic signed [31:0] imm_b(input logic [31:0] w);
    imm_b = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
  endfunction

  function automatic logic [1:0] bht_next(input logic [1:0] c, input logic taken);
    if (taken) bht_next = (c == 2'b11) ? c : c + 2'b01;
    else       bht_next = (c == 2'b00) ? c : c - 2'b01;
  endfunction

  assign line_idx   = pc_q[ICACHE_IDX+1:2];
  assign line_tag   = pc_q[31:ICACHE_IDX+2];
  assign line       = data_q[line_idx];
  assign hit        = valid_q[line_idx] && (tag_q[line_idx] == line_tag);
  assign bht_rd_idx = pc_q[BHT_IDX+1:2];
  assign bht_wr_idx = bp_pc[BHT_IDX+1:2];
  assign bp_unused  = ^{bp_pc[31:BHT_IDX+2], bp_pc[1:0]};

  // Next-PC prediction from the word currently addressed by the PC.
  always_comb begin
    npc        = pc_q + 32'd4;
    pred_taken = 1'b0;
    if (line[6:0] == OP_JAL) begin
      npc        = pc_q + $unsigned(imm_j(line));
      pred_taken = 1'b1;
    end else if (line[6:0] == OP_BRANCH && bht_q[bht_rd_idx][1]) begin
      npc        = pc_q + $unsigned(imm_b(line));
      pred_taken = 1'b1;
    end
  end

  // Fetch FSM next state: rollback wins, otherwise issue on hit or start a miss.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_done_d = 1'b0;
    inst_d      = inst_q;
    inst_pc_d   = inst_pc_q;
    pre_j_d     = pre_j_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    fill_we     = 1'b0;
    if (rollback) begin
      pc_d      = rollback_pc;
      mem_req_d = 1'b0;
      state_d   = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            if (!issue_stall) begin
              inst_done_d = 1'b1;
              inst_d      = line;
              inst_pc_d   = pc_q;
              pre_j_d     = pred_taken;
              pc_d        = npc;
            end
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = {pc_q[31:2], 2'b00};
            state_d    = WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          if (mem_done) begin
            fill_we   = 1'b1;
            mem_req_d = 1'b0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      inst_done_q <= 1'b0;
      inst_q      <= '0;
      inst_pc_q   <= '0;
      pre_j_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_done_q <= inst_done_d;
      inst_q      <= inst_d;
      inst_pc_q   <= inst_pc_d;
      pre_j_q     <= pre_j_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  // Line valid bits: cleared on reset, set by a fill.
  always_ff @(posedge clk) begin
    if (!rst) valid_q <= '0;
    else if (rdy && fill_we) valid_q[line_idx] <= 1'b1;
  end

  // Line tag/data storage; the PC is stable during a miss so it indexes the fill.
  always_ff @(posedge clk) begin
    if (rdy && fill_we) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= mem_data;
    end
  end

  // Branch history: weakly not-taken at reset, saturating update on resolve.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
    end else if (rdy && bp_upd) begin
      bht_q[bht_wr_idx] <= bht_next(bht_q[bht_wr_idx], bp_taken);
    end
  end

  // A held pulse is masked while stalled by rdy so it is seen exactly once.
  assign inst_done = inst_done_q & rdy;
  assign inst      = inst_q;
  assign inst_pc   = inst_pc_q;
  assign pre_j     = pre_j_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a bench-side instruction memory.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback, issue_stall;
  logic [31:0] rollback_pc;
  logic        inst_done, pre_j, mem_req, mem_done;
  logic [31:0] inst, inst_pc, mem_addr, mem_data;
  logic        bp_upd, bp_taken;
  logic [31:0] bp_pc;

  int checks = 0;
  int passes = 0;
  logic mem_auto = 1'b0;

  localparam logic [31:0] ADDI   = 32'h00100093;
  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] JAL20  = 32'h020000EF;  // jal x1, +0x20
  localparam logic [31:0] BEQ40  = 32'h04000063;  // beq x0, x0, +0x40

  logic [31:0] mem [logic [31:0]];

  inst_fetch dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .rollback_pc(rollback_pc),
    .issue_stall(issue_stall), .inst_done(inst_done), .inst(inst), .inst_pc(inst_pc),
    .pre_j(pre_j), .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done),
    .mem_data(mem_data), .bp_upd(bp_upd), .bp_pc(bp_pc), .bp_taken(bp_taken)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memrd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return NOP;
  endfunction

  // Automatic memory responder: one-cycle mem_done after seeing a request.
  always @(posedge clk) begin
    #1;
    if (mem_auto) begin
      if (mem_done) mem_done = 1'b0;
      else if (mem_req) begin
        mem_data = memrd(mem_addr);
        mem_done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] a);
    rollback    = 1'b1;
    rollback_pc = a;
    tick();
    rollback    = 1'b0;
  endtask

  task automatic wait_issue(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (inst_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0; rollback_pc = '0; issue_stall = 1'b0;
    mem_done = 1'b0; mem_data = '0; bp_upd = 1'b0; bp_pc = '0; bp_taken = 1'b0;
    tick(); tick();
    checks++; if (inst_done !== 1'b0) $display("FAIL rst_inst_done: got %0b want 0", inst_done); else passes++;
    checks++; if (inst !== 32'h0) $display("FAIL rst_inst: got %h want 0", inst); else passes++;
    checks++; if (inst_pc !== 32'h0) $display("FAIL rst_inst_pc: got %h want 0", inst_pc); else passes++;
    checks++; if (pre_j !== 1'b0) $display("FAIL rst_pre_j: got %0b want 0", pre_j); else passes++;
    checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %0b want 0", mem_req); else passes++;
    checks++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr: got %h want 0", mem_addr); else passes++;
  endtask

  task automatic test_cold_start();
    rst = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0)
      $display("FAIL cold_miss: got req=%0b addr=%h want req=1 addr=0", mem_req, mem_addr); else passes++;
    mem_data = memrd(32'h0); mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    checks++; if (mem_req !== 1'b0 || inst_done !== 1'b0)
      $display("FAIL cold_fill: got req=%0b done=%0b want 0 0", mem_req, inst_done); else passes++;
    tick();
    checks++; if (inst_done !== 1'b1 || inst !== ADDI || inst_pc !== 32'h0 || pre_j !== 1'b0)
      $display("FAIL cold_issue: got done=%0b inst=%h pc=%h pj=%0b want 1 %h 0 0",
               inst_done, inst, inst_pc, pre_j, ADDI); else passes++;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h4)
      $display("FAIL cold_next_pc: got req=%0b addr=%h want 1 4", mem_req, mem_addr); else passes++;
    mem_auto = 1'b1;
  endtask

  task automatic test_straight_line();
    int n = 0;
    while (!(inst_done === 1'b1 && inst_pc === 32'hC) && n < 100) begin
      tick(); n++;
    end
    checks++; if (n >= 100) $display("FAIL warm_prefill: got timeout want issue of pc c"); else passes++;
    redirect(32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (inst_done !== 1'b1 || inst_pc !== 32'(4 * k))
        $display("FAIL warm_issue%0d: got done=%0b pc=%h want 1 %h", k, inst_done, inst_pc, 32'(4 * k)); else passes++;
    end
  endtask

  task automatic test_rdy_freeze();
    redirect(32'h0);
    tick();
    checks++; if (inst_done !== 1'b1 || inst_pc !== 32'h0)
      $display("FAIL rdy_pre: got done=%0b pc=%h want 1 0", inst_done, inst_pc); else passes++;
    rdy = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (inst_done !== 1'b0 || inst_pc !== 32'h0)
        $display("FAIL rdy_frozen%0d: got done=%0b pc=%h want 0 0", k, inst_done, inst_pc); else passes++;
    end
    rdy = 1'b1;
    tick();
    checks++; if (inst_done !== 1'b1 || inst_pc !== 32'h4)
      $display("FAIL rdy_resume: got done=%0b pc=%h want 1 4", inst_done, inst_pc); else passes++;
  endtask

  task automatic test_jal();
    logic ok;
    redirect(32'h10);
    wait_issue(ok);
    checks++; if (!ok || inst_pc !== 32'h10 || inst !== JAL20 || pre_j !== 1'b1)
      $display("FAIL jal_issue: got ok=%0b pc=%h inst=%h pj=%0b want 1 10 %h 1", ok, inst_pc, inst, pre_j, JAL20); else passes++;
    wait_issue(ok);
    checks++; if (!ok || inst_pc !== 32'h30 || pre_j !== 1'b0)
      $display("FAIL jal_target: got ok=%0b pc=%h pj=%0b want 1 30 0", ok, inst_pc, pre_j); else passes++;
  endtask

  task automatic bp_pulse(input logic taken, input int count);
    bp_pc = 32'h40; bp_taken = taken; bp_upd = 1'b1;
    for (int i = 0; i < count; i++) tick();
    bp_upd = 1'b0;
  endtask

  task automatic test_branch();
    logic ok;
    redirect(32'h40);
    wait_issue(ok);
    checks++; if (!ok || inst_pc !== 32'h40 || pre_j !== 1'b0)
      $display("FAIL br_cold: got ok=%0b pc=%h pj=%0b want 1 40 0", ok, inst_pc, pre_j); else passes++;
    wait_issue(ok);
    checks++; if (!ok || inst_pc !== 32'h44)
      $display("FAIL br_fallthru: got ok=%0b pc=%h want 1 44", ok, inst_pc); else passes++;
    bp_pulse(1'b1, 2);
    redirect(32'h40);
    wait_issue(ok);
    checks++; if (!ok || inst_pc !== 32'h40 || pre_j !== 1'b1)
      $display("FAIL br_trained: got ok=%0b pc=%h pj=%0b want 1 40 1", ok, inst_pc, pre_j); else passes++;
    wait_issue(ok);
    checks++; if (!ok || inst_pc !== 32'h80)
      $display("FAIL br_target: got ok=%0b pc=%h want 1 80", ok, inst_pc); else passes++;
    // Counter 3 saturates on a third taken; two not-taken then leave it at 1.
    bp_pulse(1'b1, 1);
    bp_pulse(1'b0, 2);
    redirect(32'h40);
    wait_issue(ok);
    checks++; if (!ok || inst_pc !== 32'h40 || pre_j !== 1'b0)
      $display("FAIL br_saturate: got ok=%0b pc=%h pj=%0b want 1 40 0", ok, inst_pc, pre_j); else passes++;
  endtask

  task automatic test_issue_stall();
    issue_stall = 1'b1;
    redirect(32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (inst_done !== 1'b0)
        $display("FAIL stall_hold%0d: got done=%0b want 0", k, inst_done); else passes++;
    end
    issue_stall = 1'b0;
    tick();
    checks++; if (inst_done !== 1'b1 || inst_pc !== 32'h0)
      $display("FAIL stall_release: got done=%0b pc=%h want 1 0", inst_done, inst_pc); else passes++;
    tick();
    checks++; if (inst_done !== 1'b1 || inst_pc !== 32'h4)
      $display("FAIL stall_next: got done=%0b pc=%h want 1 4", inst_done, inst_pc); else passes++;
  endtask

  task automatic test_rollback_miss();
    mem_auto = 1'b0;
    tick();
    mem_done = 1'b0;
    redirect(32'h200);
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h200)
      $display("FAIL rb_miss_start: got req=%0b addr=%h want 1 200", mem_req, mem_addr); else passes++;
    rollback = 1'b1; rollback_pc = 32'h100; mem_done = 1'b1; mem_data = ADDI;
    tick();
    rollback = 1'b0; mem_done = 1'b0;
    checks++; if (mem_req !== 1'b0 || inst_done !== 1'b0)
      $display("FAIL rb_cancel: got req=%0b done=%0b want 0 0", mem_req, inst_done); else passes++;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100)
      $display("FAIL rb_new_miss: got req=%0b addr=%h want 1 100", mem_req, mem_addr); else passes++;
    mem_data = memrd(32'h100); mem_done = 1'b1;
    tick();
    mem_done = 1'b0;
    tick();
    checks++; if (inst_done !== 1'b1 || inst_pc !== 32'h100)
      $display("FAIL rb_issue: got done=%0b pc=%h want 1 100", inst_done, inst_pc); else passes++;
    redirect(32'h200);
    tick();
    checks++; if (inst_done !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h200)
      $display("FAIL rb_no_fill: got done=%0b req=%0b addr=%h want 0 1 200", inst_done, mem_req, mem_addr); else passes++;
  endtask

  task automatic test_reset_mid_miss();
    rst = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b0)
      $display("FAIL rstmid_drop: got req=%0b want 0", mem_req); else passes++;
    rst = 1'b1;
    tick();
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0)
      $display("FAIL rstmid_restart: got req=%0b addr=%h want 1 0", mem_req, mem_addr); else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mem[32'h0]   = ADDI;
    mem[32'h4]   = 32'h00200113;
    mem[32'h8]   = 32'h00300193;
    mem[32'hC]   = 32'h00400213;
    mem[32'h10]  = JAL20;
    mem[32'h40]  = BEQ40;
    mem[32'h100] = 32'h00500293;
    test_reset();
    test_cold_start();
    test_straight_line();
    test_rdy_freeze();
    test_jal();
    test_branch();
    test_issue_stall();
    test_rollback_miss();
    test_reset_mid_miss();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
